// File: rtl/matmul_pkg.sv
// Shared constants for the matmul APB front-end: bus geometry, region map,
// control-field layout and the APB FSM state type.
package matmul_pkg;

  localparam int unsigned DATA_WIDTH  = 8;
  localparam int unsigned BUS_WIDTH   = 32;
  localparam int unsigned MAX_DIM     = BUS_WIDTH / DATA_WIDTH;
  localparam int unsigned ADDR_WIDTH  = 16;
  localparam int unsigned SP_NTARGETS = 4;

  localparam logic [4:0] REG_CONTROL   = 5'h00;
  localparam logic [4:0] REG_OPERAND_A = 5'h04;
  localparam logic [4:0] REG_OPERAND_B = 5'h08;
  localparam logic [4:0] REG_FLAGS     = 5'h0C;
  localparam logic [4:0] REG_SP0       = 5'h10;
  localparam logic [4:0] REG_SP1       = 5'h14;
  localparam logic [4:0] REG_SP2       = 5'h18;
  localparam logic [4:0] REG_SP3       = 5'h1C;

  // bit0 is the self-clearing start request; mode/target/n/k/m live in [13:1]
  localparam int unsigned CTRL_WIDTH     = 16;
  localparam int unsigned CTRL_START_BIT = 0;
  localparam int unsigned CTRL_FIELD_LSB = 1;
  localparam int unsigned CTRL_FIELD_MSB = 13;
  localparam logic [CTRL_WIDTH-1:0] CTRL_STORE_MASK =
    ((16'h1 << (CTRL_FIELD_MSB + 1)) - 16'h1) & ~((16'h1 << CTRL_FIELD_LSB) - 16'h1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_SP_WAIT
  } apb_state_t;

endpackage

// File: rtl/matmul_apb_regbank.sv
// Byte-strobed MAX_DIM x BUS_WIDTH register array holding one operand matrix,
// exposed both as a flat vector and as a single selected row.
module matmul_apb_regbank #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned BUS_WIDTH  = 32,
  parameter int unsigned MAX_DIM    = 4
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         we_i,
  input  logic [$clog2(MAX_DIM)-1:0]   line_i,
  input  logic [BUS_WIDTH/DATA_WIDTH-1:0] strb_i,
  input  logic [BUS_WIDTH-1:0]         wdata_i,
  output logic [BUS_WIDTH-1:0]         rdata_o,
  output logic [BUS_WIDTH*MAX_DIM-1:0] flat_o
);

  localparam int unsigned ROW_W  = $clog2(MAX_DIM);
  localparam int unsigned NLANES = BUS_WIDTH / DATA_WIDTH;

  logic [BUS_WIDTH-1:0] row [MAX_DIM];

  for (genvar r = 0; r < MAX_DIM; r++) begin : g_row
    for (genvar b = 0; b < NLANES; b++) begin : g_lane
      logic [DATA_WIDTH-1:0] lane_q;
      always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
          lane_q <= '0;
        end else if (we_i && strb_i[b] && (line_i == ROW_W'(r))) begin
          lane_q <= wdata_i[b*DATA_WIDTH +: DATA_WIDTH];
        end
      end
      assign flat_o[r*BUS_WIDTH + b*DATA_WIDTH +: DATA_WIDTH] = lane_q;
    end
    assign row[r] = flat_o[r*BUS_WIDTH +: BUS_WIDTH];
  end

  assign rdata_o = row[line_i];

endmodule

// File: rtl/matmul_apb_slave.sv
// APB3 slave front-end of the matmul accelerator: operand/control registers,
// start pulse and one-wait-state scratchpad reads.
// Define MATMUL_APB_ERR_EN to drive pslverr_o; otherwise errors are silent.
module matmul_apb_slave
  import matmul_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = matmul_pkg::DATA_WIDTH,
  parameter int unsigned BUS_WIDTH   = matmul_pkg::BUS_WIDTH,
  parameter int unsigned MAX_DIM     = BUS_WIDTH / DATA_WIDTH,
  parameter int unsigned ADDR_WIDTH  = matmul_pkg::ADDR_WIDTH,
  parameter int unsigned SP_NTARGETS = matmul_pkg::SP_NTARGETS
) (
  input  logic                               clk_i,
  input  logic                               rst_i,
  input  logic                               psel_i,
  input  logic                               penable_i,
  input  logic                               pwrite_i,
  input  logic [MAX_DIM-1:0]                 pstrb_i,
  input  logic [ADDR_WIDTH-1:0]              paddr_i,
  input  logic [BUS_WIDTH-1:0]               pwdata_i,
  output logic [BUS_WIDTH-1:0]               prdata_o,
  output logic                               pready_o,
  output logic                               pslverr_o,
  output logic [BUS_WIDTH*MAX_DIM-1:0]       a_rows_o,
  output logic [BUS_WIDTH*MAX_DIM-1:0]       b_cols_o,
  output logic [15:0]                        control_o,
  output logic                               start_o,
  input  logic                               busy_i,
  input  logic [MAX_DIM*MAX_DIM-1:0]         flags_i,
  output logic                               sp_rd_en_o,
  output logic [$clog2(SP_NTARGETS)-1:0]     sp_rd_sel_o,
  output logic [2*$clog2(MAX_DIM)-1:0]       sp_rd_addr_o,
  input  logic [BUS_WIDTH-1:0]               sp_rd_data_i
);

  localparam int unsigned LINE_W = ADDR_WIDTH - 5;
  localparam int unsigned ROW_W  = $clog2(MAX_DIM);
  localparam int unsigned SPA_W  = 2 * ROW_W;
  localparam int unsigned SEL_W  = $clog2(SP_NTARGETS);
  localparam logic [LINE_W-1:0] OP_LINES = LINE_W'(MAX_DIM);
  localparam logic [LINE_W-1:0] SP_LINES = LINE_W'(MAX_DIM * MAX_DIM);

  apb_state_t state_q, state_d;
  logic [15:0] ctrl_q, ctrl_d;
  logic        start_q, start_d;

  logic [4:0]        region;
  logic [LINE_W-1:0] line;
  logic is_ctrl, is_a, is_b, is_flags, is_sp, line_ok, err;
  logic wr_a, wr_b, wr_ctrl;
  logic [BUS_WIDTH-1:0] a_rd, b_rd, rd_mux;

  assign region   = paddr_i[4:0];
  assign line     = paddr_i[ADDR_WIDTH-1:5];
  assign is_ctrl  = (region == REG_CONTROL);
  assign is_a     = (region == REG_OPERAND_A);
  assign is_b     = (region == REG_OPERAND_B);
  assign is_flags = (region == REG_FLAGS);
  assign is_sp    = (region == REG_SP0) || (region == REG_SP1) ||
                    (region == REG_SP2) || (region == REG_SP3);

  always_comb begin
    line_ok = 1'b1;
    if (is_a || is_b) begin
      line_ok = (line < OP_LINES);
    end else if (is_sp) begin
      line_ok = (line < SP_LINES);
    end
  end

  // busy_i is sampled in the ACCESS cycle itself, so a start write racing a
  // rising busy is rejected
  assign err = !(is_ctrl || is_a || is_b || is_flags || is_sp) || !line_ok ||
               (pwrite_i && (is_flags || is_sp)) ||
               (pwrite_i && busy_i && (is_ctrl || is_a || is_b));

  always_comb begin
    rd_mux = '0;
    if (is_ctrl) begin
      rd_mux = BUS_WIDTH'(ctrl_q);
    end else if (is_a) begin
      rd_mux = a_rd;
    end else if (is_b) begin
      rd_mux = b_rd;
    end else if (is_flags) begin
      rd_mux = BUS_WIDTH'(flags_i);
    end
  end

  always_comb begin
    state_d    = state_q;
    pready_o   = 1'b0;
    pslverr_o  = 1'b0;
    prdata_o   = '0;
    sp_rd_en_o = 1'b0;
    wr_a       = 1'b0;
    wr_b       = 1'b0;
    wr_ctrl    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (psel_i && !penable_i) state_d = ST_ACCESS;
      end
      ST_ACCESS: begin
        state_d = ST_IDLE;
        if (psel_i) begin
          if (is_sp && !pwrite_i && !err) begin
            sp_rd_en_o = 1'b1;
            state_d    = ST_SP_WAIT;
          end else begin
            pready_o = 1'b1;
`ifdef MATMUL_APB_ERR_EN
            pslverr_o = err;
`endif
            if (!err) begin
              if (pwrite_i) begin
                wr_ctrl = is_ctrl;
                wr_a    = is_a;
                wr_b    = is_b;
              end else begin
                prdata_o = rd_mux;
              end
            end
          end
        end
      end
      ST_SP_WAIT: begin
        state_d = ST_IDLE;
        if (psel_i) begin
          pready_o = 1'b1;
          prdata_o = sp_rd_data_i;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ctrl_d = ctrl_q;
    if (wr_ctrl) begin
      if (pstrb_i[0]) ctrl_d[7:0]  = pwdata_i[7:0];
      if (pstrb_i[1]) ctrl_d[15:8] = pwdata_i[15:8];
      ctrl_d = ctrl_d & CTRL_STORE_MASK;
    end
    start_d = wr_ctrl && pstrb_i[0] && pwdata_i[CTRL_START_BIT];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      ctrl_q  <= '0;
      start_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ctrl_q  <= ctrl_d;
      start_q <= start_d;
    end
  end

  assign control_o    = ctrl_q;
  assign start_o      = start_q;
  assign sp_rd_sel_o  = paddr_i[2 +: SEL_W];
  assign sp_rd_addr_o = line[SPA_W-1:0];

  matmul_apb_regbank #(
    .DATA_WIDTH(DATA_WIDTH),
    .BUS_WIDTH (BUS_WIDTH),
    .MAX_DIM   (MAX_DIM)
  ) u_bank_a (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (wr_a),
    .line_i (line[ROW_W-1:0]),
    .strb_i (pstrb_i),
    .wdata_i(pwdata_i),
    .rdata_o(a_rd),
    .flat_o (a_rows_o)
  );

  matmul_apb_regbank #(
    .DATA_WIDTH(DATA_WIDTH),
    .BUS_WIDTH (BUS_WIDTH),
    .MAX_DIM   (MAX_DIM)
  ) u_bank_b (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we_i   (wr_b),
    .line_i (line[ROW_W-1:0]),
    .strb_i (pstrb_i),
    .wdata_i(pwdata_i),
    .rdata_o(b_rd),
    .flat_o (b_cols_o)
  );

endmodule

// File: doc/matmul_apb_slave.md
Name: matmul_apb_slave

Overview:
- APB3 slave front-end of the matrix-multiply accelerator; the stage directly downstream of the APB stimulus/master and directly upstream of the matmul compute core.
- Decodes APB accesses into five register regions: the operand-A row bank, the operand-B column bank, the control register, the flags register, and the four scratchpad (SP) read windows.
- Drives static operand and control vectors plus a one-cycle start pulse into the core, and sequences registered SP reads back onto prdata.

Parameters:
- DATA_WIDTH, 8, width of one matrix element.
- BUS_WIDTH, 32, APB data width.
- MAX_DIM, BUS_WIDTH/DATA_WIDTH (4), maximum matrix dimension.
- ADDR_WIDTH, 16, APB address width.
- SP_NTARGETS, 4, number of scratchpad banks.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset.
- psel_i, penable_i, pwrite_i  in  1 each  APB controls.
- pstrb_i  in  MAX_DIM  byte strobes.
- paddr_i  in  ADDR_WIDTH  address: [4:0] selects the region, [ADDR_WIDTH-1:5] is the line index.
- pwdata_i  in  BUS_WIDTH  write data.
- prdata_o  out  BUS_WIDTH  read data.
- pready_o, pslverr_o  out  1 each  APB response.
- a_rows_o  out  BUS_WIDTH*MAX_DIM  operand-A rows, row i at [i*BUS_WIDTH+:BUS_WIDTH].
- b_cols_o  out  BUS_WIDTH*MAX_DIM  operand-B columns.
- control_o  out  16  control register, with bit0 always read as 0.
- start_o  out  1  start pulse.
- busy_i  in  1  core busy.
- flags_i  in  MAX_DIM*MAX_DIM  core overflow flags.
- sp_rd_en_o  out  1  SP read strobe.
- sp_rd_sel_o  out  2  SP bank select.
- sp_rd_addr_o  out  2*log2(MAX_DIM)  SP element index.
- sp_rd_data_i  in  BUS_WIDTH  SP data, valid one cycle after sp_rd_en_o.

Interface decision: one clock; reset is asynchronous and active-high.

Behaviour:
- Region map on paddr[4:0]:
  - 0x00 CONTROL.
  - 0x04 OPERAND_A; line < MAX_DIM.
  - 0x08 OPERAND_B; line < MAX_DIM.
  - 0x0C FLAGS; read-only, zero-extended.
  - 0x10/0x14/0x18/0x1C SP0..SP3; read-only, line < MAX_DIM*MAX_DIM.
  - Any other value of [4:0] is illegal.
- FSM states: IDLE, ACCESS, SP_WAIT.
  - IDLE → ACCESS when psel_i=1 and penable_i=0.
  - ACCESS, register access: pready_o=1 in the same cycle (zero wait states), then → IDLE.
  - ACCESS, SP read: assert sp_rd_en_o with sel = paddr[3:2] and addr = line; pready_o=0; → SP_WAIT.
  - SP_WAIT: prdata_o = sp_rd_data_i (registered), pready_o=1; → IDLE.
  - SP read therefore takes one wait state.
- Writes:
  - Byte lane b updates only when pstrb_i[b]=1.
  - Register update happens at the ACCESS edge where pready_o=1.
- CONTROL write with pwdata[0]=1:
  - start_o=1 for exactly the next cycle.
  - Stored bit0 stays 0.
  - Remaining fields [13:1] are stored as written: mode, write/read target, n, k, m.
- busy_i=1: writes to OPERAND_A, OPERAND_B or CONTROL are error accesses; registers are unchanged and no start pulse is issued.
- Error access:
  - Triggers: illegal region, line out of range, write to FLAGS/SP, or the busy write above.
  - pslverr_o=1 together with pready_o, for one cycle.
  - No state change; prdata_o = 0.
- Reads return the full register regardless of pstrb_i; pstrb_i must be 0 on reads and is ignored.
- psel_i dropping mid-transfer: FSM returns to IDLE and no write occurs. A transfer abandoned in SP_WAIT discards its data.
- Simultaneous start write and busy_i rising in the same cycle: busy_i is sampled in ACCESS, so the write is rejected if busy_i=1 in that cycle.
- Reset (asynchronous, any time, including mid-transfer):
  - FSM → IDLE.
  - All operand, control and prdata registers → 0.
  - pready_o, pslverr_o, start_o, sp_rd_en_o → 0.

Optional Feature:
- Macro MATMUL_APB_ERR_EN.
- Defined: pslverr_o is generated as above.
- Undefined: pslverr_o is tied to 0; illegal writes are silently dropped and illegal reads return 0 with normal pready_o timing.

Decomposition:
- matmul_pkg holds DATA_WIDTH, BUS_WIDTH, MAX_DIM, ADDR_WIDTH, the region address constants (CONTROL, OPERAND_A, OPERAND_B, FLAGS, SP0..SP3), and the control-field bit positions as localparams.
- The FSM state enum lives in the package as typedef apb_state_t.
- One sub-module: matmul_apb_regbank, the byte-strobed MAX_DIM×BUS_WIDTH register array, instantiated twice (A and B).

Test Plan:
1. Write OPERAND_A line 2, data 0x04030201, pstrb 1111 → a_rows_o[95:64]=0x04030201 on the next cycle; pready_o=1 in the first ACCESS cycle.
2. Write OPERAND_B line 0, data 0xAABBCCDD, pstrb 0101, over an old value of 0 → b_cols_o[31:0]=0x00BB00DD.
3. Write CONTROL 0x3305 → start_o high exactly 1 cycle; CONTROL readback = 0x3304.
4. Preload SP2 element 5 = 0x12345678, read 0x18 with line 5 → sp_rd_sel_o=2, sp_rd_addr_o=5; one wait state; prdata_o=0x12345678.
5. Hold busy_i=1, write OPERAND_A line 0 → pslverr_o=1 with macro defined, 0 without; a_rows_o unchanged.
6. Assert rst_i during SP_WAIT → outputs cleared asynchronously; the next transfer completes normally.
